multu_hilo_ctrl: RTL



---
 rtl/multu_hilo_ctrl_pkg.sv | 37 +++
 rtl/multu_shift_add.sv | 58 +++++
 rtl/multu_hilo_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/multu_hilo_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// multu_hilo_ctrl_pkg
//
// Purpose:
//   Shared definitions for the MULTU / HI-LO controller:
//     - 6-bit function codes, decoded identically to the ALU result mux
//     - FSM state encoding for the multiply sequencer
//
// Contents:
//   F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL   result-mux codes (never stall)
//   F_MULTU, F_MFHI, F_MFLO                   codes this block acts on
//   state_e                                   IDLE / MUL / DONE
// ----------------------------------------------------------------------------
package multu_hilo_ctrl_pkg;

    // Function codes shared with the ALU result mux.
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;

    // Codes that touch the HI/LO path.
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    // Multiply sequencer states. Encoding is fixed so the debug output can
    // be decoded by anything watching it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : multu_hilo_ctrl_pkg

// File: rtl/multu_shift_add.sv
// ----------------------------------------------------------------------------
// multu_shift_add
//
// Purpose:
//   Datapath of the 32-iteration unsigned shift-add multiplier. Holds the
//   latched multiplicand and the 2*WIDTH-bit product/multiplier register and
//   performs one add-and-shift per cycle when stepped.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high, clears both registers
//   i_load     in   latch i_a as multiplicand, product <= {0, i_b}
//   i_step     in   perform one iteration
//   i_a        in   multiplicand operand
//   i_b        in   multiplier operand
//   o_step     out  value the product register takes after this iteration;
//                   the controller captures HI/LO from it on the last step
// ----------------------------------------------------------------------------
module multu_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_step
);

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH:0]     w_upper;

    // Upper half is widened by one bit so the carry out of the add survives
    // the right shift; dropping it would corrupt large products.
    always_comb begin
        w_upper = {1'b0, r_product[2*WIDTH-1:WIDTH]};
        if (r_product[0]) begin
            w_upper = {1'b0, r_product[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        end
    end

    assign o_step = {w_upper, r_product[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand   <= '0;
            r_product <= '0;
        end else if (i_load) begin
            r_mcand   <= i_a;
            r_product <= {{WIDTH{1'b0}}, i_b};
        end else if (i_step) begin
            r_product <= o_step;
        end
    end

endmodule : multu_shift_add

// File: rtl/multu_hilo_ctrl.sv
// ----------------------------------------------------------------------------
// multu_hilo_ctrl
//
// Purpose:
//   Sequencing controller for the ALU MULTU path. Accepts unsigned multiply
//   requests, runs a WIDTH-cycle shift-add multiply, owns the HI/LO registers
//   feeding the result mux, and stalls MFHI/MFLO/MULTU while a multiply is in
//   flight so the mux never sees a stale or partial HI/LO.
//
// Handshake:
//   A MULTU is accepted on a rising edge where req_valid=1, Signal=MULTU and
//   req_ready=1 (IDLE or DONE). req_ready is low only while MUL runs; any
//   MULTU/MFHI/MFLO presented then raises stall instead.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high, clears all state
//   req_valid    in   request present this cycle
//   req_ready    out  a MULTU can be accepted this cycle
//   Signal       in   6-bit function code of the current request
//   dataA        in   multiplicand (MULTU only)
//   dataB        in   multiplier (MULTU only)
//   HiOut        out  HI register
//   LoOut        out  LO register
//   busy         out  multiply in progress
//   done         out  one-cycle pulse in the cycle HI/LO first show a result
//   stall        out  hold pipeline (combinational)
//   o_dbg_state  out  current FSM state (state_e encoding)
//
// Timing:
//   Accept edge N; iterations at edges N+1 .. N+WIDTH; HI/LO are written at
//   edge N+WIDTH together with the MUL->DONE transition, so in the DONE cycle
//   done=1 and MFHI/MFLO already read the new values.
// ----------------------------------------------------------------------------
module multu_hilo_ctrl
    import multu_hilo_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6     // 2**CNT_W must exceed WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [1:0]       o_dbg_state
);

    state_e             r_state;
    state_e             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_multu;
    logic               w_is_mfhi;
    logic               w_is_mflo;
    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic [2*WIDTH-1:0] w_step_val;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign w_is_multu = (Signal == F_MULTU);
    assign w_is_mfhi  = (Signal == F_MFHI);
    assign w_is_mflo  = (Signal == F_MFLO);

    // Accept in IDLE and also in DONE, which gives back-to-back multiplies.
    assign w_accept = req_valid & w_is_multu &
                      ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_step   = (r_state == ST_MUL);
    assign w_last   = w_step & (r_cnt == CNT_W'(WIDTH - 1));

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    multu_shift_add #(
        .WIDTH (WIDTH)
    ) u_shift_add (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept),
        .i_step (w_step),
        .i_a    (dataA),
        .i_b    (dataB),
        .o_step (w_step_val)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        req_ready    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_MUL;
                end
            end
            ST_MUL: begin
                busy      = 1'b1;
                req_ready = 1'b0;
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = w_accept ? ST_MUL : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Only HI/LO readers and a second MULTU need to wait; other ALU codes
    // do not depend on this unit.
    assign stall = req_valid & busy & (w_is_mfhi | w_is_mflo | w_is_multu);

    // ------------------------------------------------------------------
    // Iteration counter and HI/LO registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_accept) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Capture the final iteration's result directly so HI/LO change
            // exactly at DONE entry and never expose a partial product.
            if (w_last) begin
                r_hi <= w_step_val[2*WIDTH-1:WIDTH];
                r_lo <= w_step_val[WIDTH-1:0];
            end
        end
    end

    assign HiOut       = r_hi;
    assign LoOut       = r_lo;
    assign o_dbg_state = r_state;

endmodule : multu_hilo_ctrl
